// File: rtl/exp_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package : exp_sched_pkg
// Brief   : Shared types and widths for the exponential-engine scheduler.
// Rev     : 1.0  initial release
// ============================================================================
package exp_sched_pkg;

  localparam int IW         = 2;
  localparam int FW         = 16;
  localparam int XW_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick: first requester at or after ptr.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] grant,
  output logic                    any
);

  localparam int IDW = $clog2(NREQ);

  function automatic logic [IDW-1:0] rot(input logic [IDW-1:0] p, input int k);
    return IDW'((int'(p) + k) % NREQ);
  endfunction

  // Scan from the farthest offset down so the nearest pending requester wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[rot(ptr, k)]) begin
        grant = rot(ptr, k);
        any   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/exp_scheduler.sv
`default_nettype none
// ============================================================================
// Module : exp_scheduler
// Brief  : Round-robin sharing of one exponential engine among NREQ clients.
// Rev    : 1.0  initial release
// ============================================================================
module exp_scheduler
  import exp_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int XW      = XW_DEFAULT,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*XW-1:0]      x_in,
  output logic [NREQ-1:0]         ack,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [IW-1:0]           rsp_int,
  output logic [FW-1:0]           rsp_frac,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    eng_start,
  output logic [XW-1:0]           eng_x,
  input  logic                    eng_done,
  input  logic [IW-1:0]           eng_int,
  input  logic [FW-1:0]           eng_frac
);

  localparam int              IDW       = $clog2(NREQ);
  localparam int              WDW       = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]  C_WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [IDW-1:0]  C_LAST_ID = IDW'(NREQ - 1);

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_grant;
  logic [WDW-1:0] r_wd;
  logic           r_done_q;

  logic [IDW-1:0] w_grant;
  logic           w_any;
  logic [NREQ-1:0] w_ack;
  logic [XW-1:0]  w_x;
  logic           w_done_rise;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .ptr   (r_ptr),
    .grant (w_grant),
    .any   (w_any)
  );

  always_comb begin
    w_ack = '0;
    w_x   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant == IDW'(i)) begin
        w_ack[i] = 1'b1;
        w_x      = x_in[i*XW +: XW];
      end
    end
  end

  // A done level left over from an earlier operation must not complete this one.
  assign w_done_rise = eng_done & ~r_done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_wd      <= '0;
      r_done_q  <= 1'b0;
      ack       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_int   <= '0;
      rsp_frac  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      eng_start <= 1'b0;
      eng_x     <= '0;
    end else begin
      r_done_q  <= eng_done;
      ack       <= '0;
      eng_start <= 1'b0;
      rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant   <= w_grant;
            eng_x     <= w_x;
            ack       <= w_ack;
            eng_start <= 1'b1;
            busy      <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wd    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_done_rise) begin
            rsp_int   <= eng_int;
            rsp_frac  <= eng_frac;
            rsp_err   <= 1'b0;
            rsp_id    <= r_grant;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else if (r_wd == C_WD_LAST) begin
            rsp_int   <= '0;
            rsp_frac  <= '0;
            rsp_err   <= 1'b1;
            rsp_id    <= r_grant;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_wd <= r_wd + WDW'(1);
          end
        end
        S_RESP: begin
          r_ptr   <= (r_grant == C_LAST_ID) ? '0 : r_grant + IDW'(1);
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exp_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_exp_scheduler
// Brief  : Randomized scoreboard bench for exp_scheduler with an engine model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_exp_scheduler;

  localparam int NREQ    = 4;
  localparam int XW      = 16;
  localparam int TIMEOUT = 64;
  localparam int IDW     = $clog2(NREQ);

  localparam int EM_NORMAL = 0;
  localparam int EM_HOLD   = 1;
  localparam int EM_NONE   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req;
  logic [NREQ*XW-1:0] x_in;
  logic [NREQ-1:0]   ack;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [1:0]        rsp_int;
  logic [15:0]       rsp_frac;
  logic              rsp_err;
  logic              busy;
  logic              eng_start;
  logic [XW-1:0]     eng_x;
  logic              eng_done;
  logic [1:0]        eng_int;
  logic [15:0]       eng_frac;

  exp_scheduler #(.NREQ(NREQ), .XW(XW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_int(rsp_int),
    .rsp_frac(rsp_frac), .rsp_err(rsp_err), .busy(busy),
    .eng_start(eng_start), .eng_x(eng_x), .eng_done(eng_done),
    .eng_int(eng_int), .eng_frac(eng_frac)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp_v);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
  endtask

  // Accelerator behaviour: e^x for x in [0,1), 2.16 fixed point, rounded.
  function automatic logic [17:0] exp_ref(input logic [15:0] x);
    real r;
    r = $exp(real'(x) / 65536.0) * 65536.0;
    return 18'($rtoi(r + 0.5));
  endfunction

  typedef struct {
    int          id;
    logic [17:0] res;
    bit          err;
  } exp_t;

  exp_t        exp_q[$];
  int          due_q[$];
  logic [15:0] pend[NREQ][$];
  int          mptr    = 0;
  int          eng_mode = EM_NORMAL;
  int          lat_min = 1;
  int          lat_max = 30;
  bit          e_active = 1'b0;

  function automatic bit pend_empty();
    for (int i = 0; i < NREQ; i++) if (pend[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Requester agent and grant predictor.
  initial begin
    req  = '0;
    x_in = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mptr = 0;
        req  = '0;
        continue;
      end
      if (ack != '0) begin
        int w;
        logic [NREQ-1:0] ea;
        w  = -1;
        ea = '0;
        for (int k = NREQ - 1; k >= 0; k--)
          if (req[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
        if (w >= 0) ea[w] = 1'b1;
        check(ack == ea, "grant", ack, ea);
        check(eng_start && busy, "start_with_ack", {eng_start, busy}, 2'b11);
        if (w >= 0) begin
          check(eng_x == x_in[w*XW +: XW], "eng_x", eng_x, x_in[w*XW +: XW]);
          exp_q.push_back('{id: w,
                            res: (eng_mode == EM_NONE) ? 18'd0 : exp_ref(x_in[w*XW +: XW]),
                            err: (eng_mode == EM_NONE)});
          void'(pend[w].pop_front());
          mptr = (w + 1) % NREQ;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i].size() != 0) begin
          req[i] = 1'b1;
          x_in[i*XW +: XW] = pend[i][0];
        end else begin
          req[i] = 1'b0;
        end
      end
    end
  end

  // Engine model.
  initial begin
    int          e_cnt;
    int          e_hold;
    logic [17:0] e_res;
    e_cnt = 0; e_hold = 0; e_res = '0;
    eng_done = 1'b0; eng_int = '0; eng_frac = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        e_active = 1'b0;
        e_hold   = 0;
        eng_done = 1'b0;
        continue;
      end
      if (eng_done && eng_mode == EM_NORMAL && e_hold == 0) eng_done = 1'b0;
      if (eng_start) begin
        e_res    = exp_ref(eng_x);
        e_active = 1'b1;
        e_cnt    = $urandom_range(lat_max, lat_min);
        e_hold   = (eng_done && eng_mode == EM_HOLD) ? 3 : 0;
        if (eng_mode == EM_NONE) begin
          e_active = 1'b0;
          due_q.push_back(cyc + 1 + TIMEOUT);
        end
      end else if (e_active) begin
        if (e_hold > 0) begin
          e_hold--;
          if (e_hold == 0) eng_done = 1'b0;
        end
        e_cnt--;
        if (e_cnt <= 0 && !eng_done) begin
          eng_done = 1'b1;
          {eng_int, eng_frac} = e_res;
          due_q.push_back(cyc + 1);
          e_active = 1'b0;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    bit   outstanding;
    exp_t e;
    int   d;
    outstanding = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        outstanding = 1'b0;
        continue;
      end
      if (eng_start) begin
        check(!outstanding, "single_in_flight", outstanding, 0);
        outstanding = 1'b1;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_rsp", rsp_id, 0);
        end else begin
          e = exp_q.pop_front();
          check(rsp_id == IDW'(e.id), "rsp_id", rsp_id, e.id);
          check(rsp_int == e.res[17:16], "rsp_int", rsp_int, e.res[17:16]);
          check(rsp_frac == e.res[15:0], "rsp_frac", rsp_frac, e.res[15:0]);
          check(rsp_err == e.err, "rsp_err", rsp_err, e.err);
          check(busy, "busy_in_resp", busy, 1);
          if (due_q.size() == 0) begin
            check(1'b0, "rsp_no_due", cyc, 0);
          end else begin
            d = due_q.pop_front();
            check(cyc == d, "rsp_timing", cyc, d);
          end
        end
        outstanding = 1'b0;
      end
    end
  end

  task automatic drain(input int budget);
    int n;
    bit empty;
    n = 0;
    empty = 1'b0;
    while (!empty && n < budget) begin
      @(negedge clk);
      n++;
      empty = (exp_q.size() == 0) && !busy && !e_active && pend_empty();
    end
    check(empty, "drain", n, budget);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ack(input int id, input int budget);
    int n;
    n = 0;
    while (!ack[id] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(ack[id], "wait_ack", n, budget);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check({ack, rsp_valid, rsp_err, busy, eng_start} == '0, "reset_ctrl",
          {ack, rsp_valid, rsp_err, busy, eng_start}, 0);
    check({rsp_id, rsp_int, rsp_frac, eng_x} == '0, "reset_data",
          {rsp_id, rsp_int, rsp_frac, eng_x}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Contention: all four at once, fresh pointer.
    pend[0].push_back(16'h3333);
    pend[1].push_back(16'hBD70);
    pend[2].push_back(16'hFFFF);
    pend[3].push_back(16'h0000);
    drain(400);

    // Single request, fixed latency.
    lat_min = 20; lat_max = 20;
    pend[0].push_back(16'hFFFF);
    drain(100);
    lat_min = 1; lat_max = 30;

    // Fairness: requester 1 streams, requester 3 joins once.
    for (int i = 0; i < 4; i++) pend[1].push_back(16'($urandom));
    wait_ack(1, 50);
    pend[3].push_back(16'h1234);
    drain(400);

    // Stale done level held between operations.
    eng_mode = EM_HOLD; lat_min = 6; lat_max = 20;
    for (int i = 0; i < 3; i++) begin
      pend[$urandom_range(NREQ-1, 0)].push_back(16'($urandom));
      drain(100);
    end
    eng_mode = EM_NORMAL; lat_min = 1; lat_max = 30;
    repeat (3) @(negedge clk);

    // Timeout, then normal service.
    eng_mode = EM_NONE;
    pend[2].push_back(16'h4000);
    drain(TIMEOUT + 50);
    eng_mode = EM_NORMAL;
    pend[0].push_back(16'h8000);
    drain(100);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      pend[$urandom_range(NREQ-1, 0)].push_back(16'($urandom));
      repeat ($urandom_range(12, 0)) @(negedge clk);
    end
    drain(3000);

    // Reset mid-WAIT; pointer left at 2 beforehand.
    pend[1].push_back(16'h2222);
    drain(100);
    lat_min = 100; lat_max = 100;
    pend[2].push_back(16'h5555);
    wait_ack(2, 50);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check({ack, rsp_valid, rsp_err, busy, eng_start} == '0, "midreset_ctrl",
          {ack, rsp_valid, rsp_err, busy, eng_start}, 0);
    check({rsp_id, rsp_int, rsp_frac, eng_x} == '0, "midreset_data",
          {rsp_id, rsp_int, rsp_frac, eng_x}, 0);
    exp_q.delete();
    due_q.delete();
    for (int i = 0; i < NREQ; i++) pend[i].delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    lat_min = 1; lat_max = 30;
    pend[1].push_back(16'h0F0F);
    pend[3].push_back(16'hF0F0);
    drain(200);
    pend[2].push_back(16'hABCD);
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exp_scheduler.md
# exp_scheduler

Shares a single `exponential` accelerator (16-bit fractional input, 2-bit integer and 16-bit fractional result, start/done handshake) among `NREQ` requesters. Round-robin arbitration picks a requester, latches its operand, pulses the engine start, waits for done, and returns the result tagged with the requester id. A watchdog aborts the operation if the engine never signals done. Sits between the accelerator and its client blocks.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `XW`, 16, operand width (unsigned fraction, 0.16)
- `TIMEOUT`, 64, max cycles in WAIT before abort (≥4)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req`  in  NREQ  per-requester request level
- `x_in`  in  NREQ*XW  operands; requester i at `[i*XW +: XW]`
- `ack`  out  NREQ  one-cycle pulse: operand of requester i latched
- `rsp_valid`  out  1  one-cycle result pulse
- `rsp_id`  out  $clog2(NREQ)  requester owning the result
- `rsp_int`  out  2  integer part of result
- `rsp_frac`  out  16  fractional part of result
- `rsp_err`  out  1  qualifies `rsp_valid`: timeout abort, result fields zero
- `busy`  out  1  high from grant until the RESP cycle inclusive
- `eng_start`  out  1  start pulse to engine
- `eng_x`  out  XW  operand to engine
- `eng_done`  in  1  engine done
- `eng_int`  in  2  engine integer result
- `eng_frac`  in  16  engine fractional result

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req` high, grant = first requester at or after round-robin pointer `ptr`; latch `x_in` slice into `eng_x`, `rsp_id`<=grant; next ISSUE. No request: stay.
- ISSUE: `ack[grant]`=1, `eng_start`=1, clear watchdog; next WAIT.
- WAIT: `eng_done` rising edge (`eng_done & ~done_q`, with `done_q` registered every cycle) captures `eng_int`/`eng_frac`, `rsp_err`=0, next RESP. Watchdog reaching TIMEOUT: results zeroed, `rsp_err`=1, next RESP. Done level held from a previous operation is ignored.
- RESP: `rsp_valid`=1; `ptr`<=grant+1 mod NREQ; next IDLE.
- Requester protocol: hold `req` and operand until `ack`; drop `req` in the `ack` cycle or re-request. `req` dropped before grant is simply not granted; no error.
- `eng_x` stable from ISSUE until RESP. `rsp_*` hold last value between pulses.
- Reset (any time, including mid-WAIT): state IDLE, `ptr`=0, watchdog 0, `done_q`=0, all outputs 0. Engine reset is external; a done arriving after reset is ignored unless it is a rising edge in WAIT.

## Timing
- All outputs registered; reset value 0 for every output.
- Request seen in IDLE at cycle 0 → `ack`, `eng_start`, `busy` at cycle 1 → WAIT from cycle 2.
- `eng_done` rises at cycle D → `rsp_valid` at D+1 → IDLE at D+2; next grant is evaluated in that IDLE cycle, next `eng_start` at D+3.
- Timeout: `rsp_valid`/`rsp_err` at cycle 2+TIMEOUT.
- Requests arriving during ISSUE/WAIT/RESP wait; no queueing beyond `req` levels.
- The same requester re-requesting immediately is served only after all other pending requesters (fairness bound: NREQ-1 operations).

## Structure
- Package `exp_sched_pkg`: state enum, `IW=2`, `FW=16`, default `XW`.
- Sub-module `rr_arbiter`: combinational priority pick from `req` and `ptr`, outputs grant index and `any`; the scheduler owns `ptr`.
- Watchdog counter and `done_q` edge detect inline.

## Test plan
- Single request: requester 0 `x=16'hFFFF`, engine model latency 20 → `ack[0]` at cycle 1, one `eng_start`, `rsp_valid` with `rsp_id=0`, `rsp_int`/`rsp_frac` equal to the model's value (2/≈16'hB7E1), `rsp_err=0`.
- Contention: all four request at once (`x=16'h3333,16'hBD70,16'hFFFF,16'h0000`) → grants 0,1,2,3 in order, each result tagged correctly, never two `eng_start` without an intervening `rsp_valid`.
- Fairness: requester 1 re-requests continuously, requester 3 requests once → 3 is granted immediately after 1's current operation.
- Stale done: engine holds `eng_done` high after an operation → next operation waits for a fresh rising edge, no early `rsp_valid`.
- Timeout: engine never asserts done → `rsp_valid` with `rsp_err=1`, results 0 exactly TIMEOUT cycles into WAIT, then a following request is served normally.
- Reset in WAIT: `rst` low mid-operation → all outputs 0 immediately, `ptr=0`; after release, requester 2 alone is granted and served.
